// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback -- final pipeline stage.
//
// Accepts accessor results (rd, rd_data) over a valid/ready handshake and
// commits them to the 32x32 architectural register file. Owns the two decoder
// read ports and a per-register pending-write scoreboard for RAW detection.
// Emits a one-cycle retire pulse after every commit and keeps a 64-bit count
// of committed results.
//
// Optional feature macro: WRITEBACK_BYPASS_EN
//   defined   : a read of the register being committed this cycle returns the
//               incoming data, and busy reflects the post-commit count.
//   undefined : reads/busy show pre-commit state; updates appear next cycle.
//
// Ports
//   clk              in   clock, all state on posedge
//   reset            in   asynchronous active-high reset
//   accessor_valid   in   upstream result valid
//   writeback_ready  out  stage can accept a result (registered)
//   in               in   accessor_output_t {rd[4:0], rd_data[31:0]}
//   rs1_addr/rs2_addr in  read port addresses
//   rs1_data/rs2_data out read port data (combinational)
//   issue_valid      in   decoder issues an instruction writing issue_rd
//   issue_rd         in   destination of the issuing instruction
//   issue_ready      out  scoreboard can record issue_rd (combinational)
//   rs1_busy/rs2_busy out write to rsN_addr still pending (combinational)
//   retire           out  one-cycle pulse the cycle after each commit
//   instret          out  count of committed results
// ---------------------------------------------------------------------------

package writeback_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rd_data;
  } accessor_output_t;

endpackage

module writeback
  import writeback_pkg::*;
#(
  parameter int unsigned PENDING_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  accessor_valid,
  output logic                  writeback_ready,
  input  accessor_output_t      in,

  input  logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]       rs1_data,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs2_data,

  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  output logic                  rs1_busy,
  output logic                  rs2_busy,

  output logic                  retire,
  output logic [63:0]           instret
);

  localparam int unsigned NREGS    = 32;
  localparam int unsigned INSTRET_W = 64;
  localparam logic [PENDING_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]      regs    [NREGS];
  logic [PENDING_W-1:0] cnt     [NREGS];
  logic [PENDING_W-1:0] cnt_nxt [NREGS];

  logic commit;
  logic commit_wr;
  logic issue_fire;
  logic issue_blocked;

  // Handshake: ready is only low in (and the cycle after) reset.
  assign commit    = accessor_valid && writeback_ready;
  assign commit_wr = commit && (in.rd != '0);

  // A saturated counter can still take an issue if a commit frees a slot
  // on the same edge.
  assign issue_blocked = (cnt[issue_rd] == CNT_MAX) &&
                         !(commit_wr && (in.rd == issue_rd));
  assign issue_ready   = !reset && !issue_blocked;
  assign issue_fire    = issue_valid && issue_ready && (issue_rd != '0);

  // Next pending counts: +1 on issue, -1 on commit (clamped at 0),
  // unchanged when both hit the same register.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = cnt[r];
    end
    for (int r = 1; r < NREGS; r++) begin
      if (issue_fire && (issue_rd == REG_ADDR_W'(r))) begin
        if (!(commit_wr && (in.rd == REG_ADDR_W'(r)))) begin
          cnt_nxt[r] = cnt[r] + PENDING_W'(1);
        end
      end else if (commit_wr && (in.rd == REG_ADDR_W'(r))) begin
        if (cnt[r] != '0) begin
          cnt_nxt[r] = cnt[r] - PENDING_W'(1);
        end
      end
    end
  end

  // Read ports; x0 is hard-wired to zero and never tracked (cnt[0] stays 0).
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`ifdef WRITEBACK_BYPASS_EN
    if (commit_wr && (rs1_addr == in.rd)) begin
      rs1_data = in.rd_data;
    end
    if (commit_wr && (rs2_addr == in.rd)) begin
      rs2_data = in.rd_data;
    end
    rs1_busy = (cnt_nxt[rs1_addr] != '0);
    rs2_busy = (cnt_nxt[rs2_addr] != '0);
`else
    rs1_busy = (cnt[rs1_addr] != '0);
    rs2_busy = (cnt[rs2_addr] != '0);
`endif
  end

  // Handshake, retire pulse and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeback_ready <= 1'b0;
      retire          <= 1'b0;
      instret         <= '0;
    end else begin
      writeback_ready <= 1'b1;
      retire          <= commit;
      if (commit) begin
        instret <= instret + INSTRET_W'(1);
      end
    end
  end

  // Architectural register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (commit_wr) begin
      regs[in.rd] <= in.rd_data;
    end
  end

  // Pending-write scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback -- self-checking bench for writeback.
// A behavioural model (arrays of register values and pending counts) is
// updated on every posedge; one compare process checks all outputs on every
// negedge. Directed scenarios add hand-computed literal expectations, then
// a randomized phase exercises handshake, scoreboard and resets.
// ---------------------------------------------------------------------------

module tb_writeback;
  import writeback_pkg::*;

  localparam int MAXC = 3;  // 2**PENDING_W - 1 with PENDING_W = 2

  logic             clk = 1'b0;
  logic             reset;
  logic             accessor_valid;
  logic             writeback_ready;
  accessor_output_t in_s;
  logic [4:0]       rs1_addr, rs2_addr;
  logic [31:0]      rs1_data, rs2_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic             rs1_busy, rs2_busy;
  logic             retire;
  logic [63:0]      instret;

  always #5 clk = ~clk;

  writeback #(.PENDING_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .accessor_valid (accessor_valid),
    .writeback_ready(writeback_ready),
    .in             (in_s),
    .rs1_addr       (rs1_addr),
    .rs1_data       (rs1_data),
    .rs2_addr       (rs2_addr),
    .rs2_data       (rs2_data),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_ready    (issue_ready),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .retire         (retire),
    .instret        (instret)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_ready;
  bit          m_retire;
  logic [63:0] m_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_ready   = 1'b0;
    m_retire  = 1'b0;
    m_instret = '0;
  endfunction

  function automatic bit m_commit();
    return accessor_valid && m_ready && !reset;
  endfunction

  function automatic bit m_commit_to(input logic [4:0] r);
    return m_commit() && (r != 0) && (in_s.rd == r);
  endfunction

  function automatic bit m_issue_ready();
    if (reset) return 1'b0;
    return !((m_cnt[issue_rd] == MAXC) && !m_commit_to(issue_rd));
  endfunction

  function automatic bit m_issue_to(input logic [4:0] r);
    return issue_valid && m_issue_ready() && (r != 0) && (issue_rd == r);
  endfunction

  // Pending count a register will hold after this cycle's edge.
  function automatic int m_count_after(input logic [4:0] r);
    int c;
    c = m_cnt[r];
    if (m_issue_to(r) && m_commit_to(r)) return c;
    if (m_issue_to(r)) c++;
    if (m_commit_to(r) && c > 0) c--;
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef WRITEBACK_BYPASS_EN
    if (m_commit_to(a)) return in_s.rd_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef WRITEBACK_BYPASS_EN
    return m_count_after(a) != 0;
`else
    return m_cnt[a] != 0;
`endif
  endfunction

  // Model update on each active edge
  always @(posedge clk) begin : model_upd
    bit c;
    int nc [32];
    if (reset) begin
      model_clear();
    end else begin
      c = m_commit();
      for (int r = 1; r < 32; r++) nc[r] = m_count_after(5'(r));
      if (c && in_s.rd != 0) m_regs[in_s.rd] = in_s.rd_data;
      for (int r = 1; r < 32; r++) m_cnt[r] = nc[r];
      m_retire = c;
      if (c) m_instret = m_instret + 64'd1;
      m_ready = 1'b1;
    end
  end

  // Single compare process, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("writeback_ready", 64'(writeback_ready), 64'(m_ready));
      chk("retire", 64'(retire), 64'(m_retire));
      chk("instret", instret, m_instret);
      chk("rs1_data", 64'(rs1_data), 64'(m_read(rs1_addr)));
      chk("rs2_data", 64'(rs2_data), 64'(m_read(rs2_addr)));
      chk("rs1_busy", 64'(rs1_busy), 64'(m_busy(rs1_addr)));
      chk("rs2_busy", 64'(rs2_busy), 64'(m_busy(rs2_addr)));
      chk("issue_ready", 64'(issue_ready), 64'(m_issue_ready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    accessor_valid = 1'b0;
    in_s           = '0;
    rs1_addr       = '0;
    rs2_addr       = '0;
    issue_valid    = 1'b0;
    issue_rd       = '0;
    model_clear();

    // 1. reset for 3 cycles, ready rises on the first edge after release
    repeat (3) step();
    cmp_en   = 1'b1;
    reset    = 1'b0;
    rs1_addr = 5'd5;
    at_mid();
    chk("ready_before_edge", 64'(writeback_ready), 64'd0);
    chk("x5_after_reset", 64'(rs1_data), 64'd0);
    chk("instret_after_reset", instret, 64'd0);
    step();
    at_mid();
    chk("ready_after_edge", 64'(writeback_ready), 64'd1);

    // 2. commit rd=5
    step();
    accessor_valid = 1'b1;
    in_s.rd        = 5'd5;
    in_s.rd_data   = 32'hDEADBEEF;
    step();
    accessor_valid = 1'b0;
    at_mid();
    chk("retire_pulse", 64'(retire), 64'd1);
    chk("x5_value", 64'(rs1_data), 64'hDEADBEEF);
    chk("instret_one", instret, 64'd1);
    step();
    at_mid();
    chk("retire_one_cycle", 64'(retire), 64'd0);

    // 3. commit to x0 retires but writes nothing
    step();
    accessor_valid = 1'b1;
    in_s.rd        = 5'd0;
    in_s.rd_data   = 32'h12345678;
    rs1_addr       = 5'd0;
    rs2_addr       = 5'd0;
    step();
    accessor_valid = 1'b0;
    at_mid();
    chk("x0_reads_zero", 64'(rs1_data), 64'd0);
    chk("retire_x0", 64'(retire), 64'd1);
    chk("instret_two", instret, 64'd2);

    // 4. three issues to x7 saturate; commits drain
    step();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    step();
    step();
    issue_valid = 1'b0;
    rs1_addr    = 5'd7;
    at_mid();
    chk("x7_busy_sat", 64'(rs1_busy), 64'd1);
    chk("x7_issue_blocked", 64'(issue_ready), 64'd0);
    step();
    accessor_valid = 1'b1;
    in_s.rd        = 5'd7;
    in_s.rd_data   = 32'h00000077;
    step();
    accessor_valid = 1'b0;
    at_mid();
    chk("x7_issue_reopen", 64'(issue_ready), 64'd1);
    chk("x7_busy_two", 64'(rs1_busy), 64'd1);
    step();
    accessor_valid = 1'b1;
    step();
    step();
    accessor_valid = 1'b0;
    at_mid();
    chk("x7_busy_clear", 64'(rs1_busy), 64'd0);
    chk("x7_value", 64'(rs1_data), 64'h77);

    // 5. same-cycle issue and commit to x9 with cnt=1
    step();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    accessor_valid = 1'b1;
    in_s.rd        = 5'd9;
    in_s.rd_data   = 32'h00000099;
    step();
    issue_valid    = 1'b0;
    accessor_valid = 1'b0;
    rs2_addr       = 5'd9;
    at_mid();
    chk("x9_busy_held", 64'(rs2_busy), 64'd1);
    chk("x9_value", 64'(rs2_data), 64'h99);

    // 6. reset in the middle of a commit to x3
    step();
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    step();
    issue_valid    = 1'b0;
    accessor_valid = 1'b1;
    in_s.rd        = 5'd3;
    in_s.rd_data   = 32'h00000033;
    rs1_addr       = 5'd3;
    @(negedge clk);
    #3;
    reset = 1'b1;
    model_clear();
    at_mid();
    chk("rst_no_retire", 64'(retire), 64'd0);
    chk("rst_x3_zero", 64'(rs1_data), 64'd0);
    chk("rst_x3_not_busy", 64'(rs1_busy), 64'd0);
    chk("rst_x9_zero", 64'(rs2_data), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ready_low", 64'(writeback_ready), 64'd0);
    step();
    reset          = 1'b0;
    accessor_valid = 1'b0;
    step();
    accessor_valid = 1'b1;
    in_s.rd        = 5'd4;
    in_s.rd_data   = 32'h000000A5;
    rs1_addr       = 5'd4;
    at_mid();
`ifdef WRITEBACK_BYPASS_EN
    chk("bypass_same_cycle", 64'(rs1_data), 64'hA5);
`else
    chk("no_bypass_same_cycle", 64'(rs1_data), 64'd0);
`endif
    step();
    accessor_valid = 1'b0;
    at_mid();
    chk("x4_after_commit", 64'(rs1_data), 64'hA5);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_clear();
      end else begin
        reset = 1'b0;
      end
      accessor_valid = ($urandom_range(0, 2) != 0);
      in_s.rd        = 5'($urandom_range(0, 7));
      in_s.rd_data   = $urandom;
      issue_valid    = ($urandom_range(0, 1) != 0);
      issue_rd       = 5'($urandom_range(0, 7));
      rs1_addr       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs2_addr       = 5'($urandom_range(0, 7));
    end
    step();
    reset = 1'b0;
    step();
    at_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
